baud_gen_frac: RTL and testbench
================================

# baud_gen_frac

Parametrised fractional baud-rate generator for the UART datapath, successor to the fixed-divider tick timer. It divides `clk` by a runtime-loadable integer+fractional divisor to produce an oversample tick (`os_tick`), a once-per-bit tick (`bit_tick`) and a mid-bit sample tick (`mid_tick`). It sits between the register block, which supplies the divisor, and the UART TX/RX engines, which consume the ticks. It supports safe divisor updates at bit boundaries and a phase restart for receiver start-bit alignment.

## Interface
- `DIV_W`, default 16: integer divisor width.
- `FRAC_W`, default 4: fractional divisor width (resolution 1/2^FRAC_W cycle).
- `OVS`, default 16: oversample ticks per bit; must be an even value ≥4.
- `DEF_INT`, default 27: integer divisor after reset.
- `DEF_FRAC`, default 0: fractional divisor after reset.
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run when high; freeze all counters when low.
- `sync_clr`  in  1  restart phase (all counters to 0).
- `div_load`  in  1  one-cycle strobe that captures `div_int`/`div_frac`.
- `div_int`  in  DIV_W  requested integer divisor, ≥2.
- `div_frac`  in  FRAC_W  requested fractional divisor.
- `os_tick`  out  1  registered one-cycle oversample tick.
- `bit_tick`  out  1  registered; high with the OVS-th `os_tick` of each bit.
- `mid_tick`  out  1  registered; high with the (OVS/2)-th `os_tick` of each bit.
- `div_err`  out  1  registered one-cycle pulse when a load is rejected.

## Operation
- **State:**
  - `cnt` (DIV_W): cycle counter.
  - `acc` (FRAC_W): fractional accumulator.
  - `ext` (1): extends the current period by one cycle.
  - `os_cnt` (log2 OVS): position within the bit.
  - Active divisor `act_int`/`act_frac`, pending divisor `pend_int`/`pend_frac` and `pend_vld`.
- **Period length:** an oversample period lasts `act_int + ext` enabled cycles.
- **Terminal count:** `last = act_int - 1 + ext`. When `enable` is high and `cnt == last`:
  - `cnt <= 0`;
  - `os_tick <= 1`;
  - `{ext, acc} <= acc + act_frac`, an FRAC_W+1-bit sum whose carry becomes `ext`;
  - `os_cnt` wraps at OVS-1.
- **Tick decode:** `bit_tick` is set on the terminal-count edge when `os_cnt == OVS-1`. `mid_tick` is set on that edge when `os_cnt == OVS/2-1`.
- **Otherwise:** when `enable` is high and `cnt != last`, `cnt` increments. When `enable` is low, all counters hold and all ticks are 0.
- **`sync_clr`:**
  - Clears `cnt`, `acc`, `ext` and `os_cnt`, and forces all ticks to 0 in that cycle.
  - Takes priority over `enable` and the terminal count.
  - Does not touch the divisor registers or pending state.
- **`div_load`:**
  - If `div_int < 2`: `div_err` pulses and the pending state is unchanged.
  - Otherwise the values are captured into `pend_*` and `pend_vld <= 1`. A later load overwrites an earlier pending one.
- **Pending apply:**
  - Applied to `act_*` on the `bit_tick` edge.
  - Also applied immediately, on the next edge, if `enable` is low or `sync_clr` is high.
  - Applying clears `pend_vld`.
  - The new divisor governs the period that starts after that edge.
- **Simultaneous events:** a `div_load` in the same cycle as an apply edge replaces the values being applied, i.e. the newest values win.
- **Arithmetic:** the fractional sum is FRAC_W+1 bits wide, and `acc` wraps modulo 2^FRAC_W.
- **Long-run divisor:** the average oversample period is `act_int + act_frac/2^FRAC_W` cycles.

## Timing
- **Reset values (while `reset` is low):**
  - all outputs 0;
  - `cnt`, `acc`, `ext` and `os_cnt` 0;
  - `act_int = DEF_INT`, `act_frac = DEF_FRAC`, `pend_vld = 0`.
- **First tick:** with `enable` held high from reset release (or from a `sync_clr` cycle), the first `os_tick` is high in the cycle after the `act_int`-th enabled rising edge.
- **Tick width:** every tick is exactly one cycle wide. No tick is produced while `enable` is low.
- **`div_err` latency:** one cycle after the `div_load` edge.
- **Reset mid-operation:** asynchronously returns everything to its reset value. A pending load is lost.

## Structure
- **Package `uart_pkg`:**
  - `MIN_DIV = 2`;
  - default `DIV_W`, `FRAC_W` and `OVS`;
  - a typedef for the divisor pair `{int, frac}`, shared with the register block.
- **Sub-module `baud_frac_acc`:** a natural split. It holds `acc`/`ext` and takes `tick_in`, `frac` and `clr`, and returns `ext`.
- **Top level:** `cnt`, `os_cnt`, the divisor shadow logic and the output registers stay in the top module.

## Test plan
- **Integer divisor:** `div_int=4`, `frac=0`, `OVS=16`, `enable` held high → `os_tick` every 4 cycles; `bit_tick` every 64 cycles, coincident with every 16th `os_tick`; `mid_tick` on the 8th `os_tick` of each bit.
- **Fractional divisor:** `div_int=4`, `div_frac=8` (`FRAC_W=4`) → periods go 4,4,5,4,5,…; first `bit_tick` after 71 cycles, each later one every 72 cycles.
- **Mid-bit load:** load `div_int=8` mid-bit → the current bit keeps period 4; after the next `bit_tick` the period is 8. Also load with `enable` low → applied on the next edge.
- **Rejected load:** load `div_int=1` → `div_err` pulses one cycle later; active and pending divisors are unchanged; the tick period stays at its old value.
- **`sync_clr` mid-count:** at `cnt=2` with `enable` high → no tick that cycle; next `os_tick` 4 cycles later; `os_cnt` restarts, so `mid_tick` comes 8 `os_tick`s later. Hold `enable` low for 10 cycles mid-period → counters freeze, no ticks, and the sequence resumes unchanged.
- **Reset mid-bit with a load pending:** → all outputs 0 immediately; after release the period reverts to `DEF_INT` (27 cycles) and the pending load is discarded.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART timing definitions: divisor limits, default widths and the
// divisor pair type exchanged with the register block.
package uart_pkg;

  localparam int MIN_DIV    = 2;
  localparam int DEF_DIV_W  = 16;
  localparam int DEF_FRAC_W = 4;
  localparam int DEF_OVS    = 16;

  typedef struct packed {
    logic [DEF_DIV_W-1:0]  int_part;
    logic [DEF_FRAC_W-1:0] frac;
  } baud_div_t;

  function automatic logic div_ok(input logic [31:0] d);
    return d >= 32'(MIN_DIV);
  endfunction

endpackage

// File: rtl/baud_gen_frac_if.sv
// Control/tick bundle between the register block, the baud generator and
// the UART TX/RX engines.
interface baud_gen_frac_if #(
  parameter int DIV_W  = uart_pkg::DEF_DIV_W,
  parameter int FRAC_W = uart_pkg::DEF_FRAC_W
);
  logic              enable;
  logic              sync_clr;
  logic              div_load;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              os_tick;
  logic              bit_tick;
  logic              mid_tick;
  logic              div_err;

  modport master (
    output enable, sync_clr, div_load, div_int, div_frac,
    input  os_tick, bit_tick, mid_tick, div_err
  );

  modport slave (
    input  enable, sync_clr, div_load, div_int, div_frac,
    output os_tick, bit_tick, mid_tick, div_err
  );
endinterface

// File: rtl/baud_frac_acc.sv
// Fractional accumulator: adds the fractional divisor once per oversample
// period; the carry stretches the following period by one cycle.
module baud_frac_acc
  import uart_pkg::*;
#(
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_in,
  input  logic              clr,
  input  logic [FRAC_W-1:0] frac,
  output logic              ext
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, frac};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      ext <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ext <= 1'b0;
    end else if (tick_in) begin
      {ext, acc} <= sum;
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: produces oversample, bit and mid-bit ticks
// from a runtime-loadable integer+fractional divisor with bit-aligned updates.
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int DIV_W    = DEF_DIV_W,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int OVS      = DEF_OVS,
  parameter int DEF_INT  = 27,
  parameter int DEF_FRAC = 0
) (
  input  logic             clk,
  input  logic             reset,
  baud_gen_frac_if.slave   bus
);

  localparam int OS_W = (OVS > 1) ? $clog2(OVS) : 1;

  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  last;
  logic [DIV_W-1:0]  act_int;
  logic [DIV_W-1:0]  pend_int;
  logic [FRAC_W-1:0] act_frac;
  logic [FRAC_W-1:0] pend_frac;
  logic              pend_vld;
  logic [OS_W-1:0]   os_cnt;
  logic              ext;
  logic              adv;
  logic              os_wrap;
  logic              bit_edge;
  logic              apply;
  logic              load_ok;
  logic              os_tick_q;
  logic              bit_tick_q;
  logic              mid_tick_q;
  logic              div_err_q;

  // Terminal count stretches by one cycle whenever the accumulator carried.
  assign last     = act_int - DIV_W'(1) + DIV_W'(ext);
  assign adv      = bus.enable && !bus.sync_clr && (cnt == last);
  assign os_wrap  = (os_cnt == OS_W'(OVS - 1));
  assign bit_edge = adv && os_wrap;
  assign apply    = pend_vld && (bus.sync_clr || !bus.enable || bit_edge);
  assign load_ok  = bus.div_load && div_ok(32'(bus.div_int));

  baud_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .tick_in (adv),
    .clr     (bus.sync_clr),
    .frac    (act_frac),
    .ext     (ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      os_cnt     <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
    end else begin
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
      if (bus.sync_clr) begin
        cnt    <= '0;
        os_cnt <= '0;
      end else if (bus.enable) begin
        if (adv) begin
          cnt        <= '0;
          os_tick_q  <= 1'b1;
          bit_tick_q <= os_wrap;
          mid_tick_q <= (os_cnt == OS_W'(OVS / 2 - 1));
          os_cnt     <= os_wrap ? '0 : os_cnt + OS_W'(1);
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

  // A valid load landing on an apply edge goes straight to the active pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_int   <= DIV_W'(DEF_INT);
      act_frac  <= FRAC_W'(DEF_FRAC);
      pend_int  <= '0;
      pend_frac <= '0;
      pend_vld  <= 1'b0;
      div_err_q <= 1'b0;
    end else begin
      div_err_q <= bus.div_load && !load_ok;
      if (apply) begin
        act_int  <= load_ok ? bus.div_int  : pend_int;
        act_frac <= load_ok ? bus.div_frac : pend_frac;
        pend_vld <= 1'b0;
      end else if (load_ok) begin
        pend_int  <= bus.div_int;
        pend_frac <= bus.div_frac;
        pend_vld  <= 1'b1;
      end
    end
  end

  assign bus.os_tick  = os_tick_q;
  assign bus.bit_tick = bit_tick_q;
  assign bus.mid_tick = mid_tick_q;
  assign bus.div_err  = div_err_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: stimulus queues expected tick events by
// cycle number, a negedge monitor pops and compares whenever any output fires.
module tb_baud_gen_frac;
  import uart_pkg::*;

  typedef struct {
    int   cyc;
    logic os;
    logic bt;
    logic md;
    logic er;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  exp_t sbq[$];
  exp_t e;
  int   per_q[$];

  baud_gen_frac_if #(.DIV_W(16), .FRAC_W(4)) bus ();

  baud_gen_frac #(
    .DIV_W    (16),
    .FRAC_W   (4),
    .OVS      (16),
    .DEF_INT  (27),
    .DEF_FRAC (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (bus.os_tick || bus.bit_tick || bus.mid_tick || bus.div_err) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d got os/bit/mid/err=%b%b%b%b required none",
                 cyc, bus.os_tick, bus.bit_tick, bus.mid_tick, bus.div_err);
      end else begin
        e = sbq.pop_front();
        if (e.cyc != cyc || e.os !== bus.os_tick || e.bt !== bus.bit_tick ||
            e.md !== bus.mid_tick || e.er !== bus.div_err) begin
          bad++;
          $display("FAIL event@%0d got cyc=%0d os/bit/mid/err=%b%b%b%b required cyc=%0d %b%b%b%b",
                   e.cyc, cyc, bus.os_tick, bus.bit_tick, bus.mid_tick, bus.div_err,
                   e.cyc, e.os, e.bt, e.md, e.er);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic push(input int c, input logic os, input logic bt, input logic md, input logic er);
    exp_t x;
    x.cyc = c; x.os = os; x.bt = bt; x.md = md; x.er = er;
    sbq.push_back(x);
  endtask

  // Expected os_tick stream for a run starting at the bit boundary at cycle base.
  task automatic push_run(input int base, output int end_c);
    int c;
    c = base;
    for (int i = 0; i < per_q.size(); i++) begin
      c += per_q[i];
      push(c, 1'b1, (i % 16) == 15, (i % 16) == 7, 1'b0);
    end
    end_c = c;
    per_q.delete();
  endtask

  task automatic do_load(input baud_div_t d);
    bus.div_load = 1'b1;
    bus.div_int  = d.int_part;
    bus.div_frac = d.frac;
    step();
    bus.div_load = 1'b0;
  endtask

  task automatic chk(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%b required=%b", name, act, req);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_os_tick"},  bus.os_tick,  1'b0);
    chk({tag, "_bit_tick"}, bus.bit_tick, 1'b0);
    chk({tag, "_mid_tick"}, bus.mid_tick, 1'b0);
    chk({tag, "_div_err"},  bus.div_err,  1'b0);
  endtask

  initial begin
    int t0, s, c1, c2, b0, b, c3, f, r, ec;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.enable   = 1'b0;
    bus.sync_clr = 1'b0;
    bus.div_load = 1'b0;
    bus.div_int  = '0;
    bus.div_frac = '0;
    step(); step(); step();
    chk_zero_outputs("reset");

    // Default divisor 27 straight out of reset
    t0 = cyc;
    push(t0 + 27, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    bus.enable = 1'b1;
    wait_until(t0 + 27);
    bus.enable = 1'b0;

    // Load 4 with enable low (applied next edge), then phase restart
    do_load(baud_div_t'{16'd4, 4'd0});
    step();
    bus.sync_clr = 1'b1;
    bus.enable   = 1'b1;
    step();
    s = cyc;
    bus.sync_clr = 1'b0;
    for (int i = 0; i < 48; i++) per_q.push_back(4);
    for (int i = 0; i < 16; i++) per_q.push_back(8);
    push_run(s, ec);
    // Mid-bit load of 8: current bit keeps period 4
    wait_until(s + 146);
    do_load(baud_div_t'{16'd8, 4'd0});
    wait_until(ec);

    // Rejected load of 1: div_err one cycle after, period stays 8
    c1 = cyc;
    push(c1 + 4, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) per_q.push_back(8);
    push_run(c1, ec);
    wait_until(c1 + 3);
    do_load(baud_div_t'{16'd1, 4'd5});
    wait_until(ec);

    // Load 4, sync_clr at cnt=2 applies it and restarts phase
    c2 = cyc;
    do_load(baud_div_t'{16'd4, 4'd0});
    step();
    bus.sync_clr = 1'b1;
    step();
    bus.sync_clr = 1'b0;
    b0 = cyc;
    b  = b0 + 15;
    per_q = '{4, 4, 4};
    push_run(b0, ec);
    per_q = '{4, 4, 4, 14};
    for (int i = 0; i < 12; i++) per_q.push_back(4);
    push_run(b, ec);
    wait_until(b0 + 14);
    bus.sync_clr = 1'b1;
    step();
    bus.sync_clr = 1'b0;
    // Freeze 10 cycles with cnt=2
    wait_until(b + 14);
    bus.enable = 1'b0;
    wait_until(b + 24);
    bus.enable = 1'b1;
    wait_until(ec);

    // Fractional divisor 4 + 8/16 loaded with enable low
    c3 = cyc;
    bus.enable = 1'b0;
    do_load(baud_div_t'{16'd4, 4'd8});
    step();
    bus.sync_clr = 1'b1;
    bus.enable   = 1'b1;
    step();
    f = cyc;
    bus.sync_clr = 1'b0;
    per_q = '{4, 4, 5, 4, 5, 4, 5, 4, 5, 4, 5, 4, 5, 4, 5, 4,
              5, 4, 5, 4, 5, 4, 5, 4, 5, 4, 5, 4, 5, 4, 5, 4, 5};
    push_run(f, ec);

    // Reset mid-bit with a pending load of 8
    wait_until(f + 149);
    do_load(baud_div_t'{16'd8, 4'd0});
    wait_until(f + 152);
    chk("os_tick_before_reset", bus.os_tick, 1'b1);
    reset = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    step(); step(); step();
    reset = 1'b1;
    r = cyc;
    for (int i = 0; i < 18; i++) per_q.push_back(27);
    push_run(r, ec);
    wait_until(ec + 5);

    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event@%0d got none required os/bit/mid/err=%b%b%b%b",
               e.cyc, e.os, e.bt, e.md, e.er);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
